// File: rtl/u_slot_alloc_if.sv
// u_slot_alloc_if: request/release/status bundle for the u_slot_alloc slot allocator.
// The requester side uses the master modport; the allocator uses the slave modport.
interface u_slot_alloc_if #(
  parameter int W = 8
);
  localparam int IW = $clog2(W);

  logic          i_alloc_vld;
  logic          o_alloc_rdy;
  logic [IW-1:0] o_alloc_idx;
  logic          i_free_vld;
  logic [IW-1:0] i_free_idx;
  logic          i_flush;
  logic [W-1:0]  o_busy;
  logic [IW:0]   o_count;
  logic          o_full;
  logic          o_empty;
  logic          o_err;

  modport master (
    output i_alloc_vld,
    output i_free_vld,
    output i_free_idx,
    output i_flush,
    input  o_alloc_rdy,
    input  o_alloc_idx,
    input  o_busy,
    input  o_count,
    input  o_full,
    input  o_empty,
    input  o_err
  );

  modport slave (
    input  i_alloc_vld,
    input  i_free_vld,
    input  i_free_idx,
    input  i_flush,
    output o_alloc_rdy,
    output o_alloc_idx,
    output o_busy,
    output o_count,
    output o_full,
    output o_empty,
    output o_err
  );
endinterface

// File: rtl/u_slot_alloc.sv
// u_slot_alloc: grants the first free slot of a W-entry occupancy bitmap and releases slots on free.
// Define U_SLOT_ALLOC_BYPASS_EN to let a full allocator hand a same-cycle freed slot straight to the requester.
module u_slot_alloc #(
  parameter int W   = 8,
  parameter int LSB = 1
) (
  input logic           clk,
  input logic           arst_n,
  u_slot_alloc_if.slave bus
);
  localparam int            IW       = $clog2(W);
  localparam logic [IW-1:0] IDX_RST  = (LSB != 0) ? IW'(0) : IW'(W - 1);
  localparam logic [IW:0]   CNT_FULL = (IW + 1)'(W);
  localparam logic [IW:0]   CNT_ONE  = (IW + 1)'(1);

  // One-hot decode; indices at or beyond W decode to all zeros.
  function automatic logic [W-1:0] slot_mask(input logic [IW-1:0] idx);
    logic [W-1:0] m;
    m = {W{1'b0}};
    for (int i = 0; i < W; i++) begin
      m[i] = (idx == IW'(i));
    end
    return m;
  endfunction

  logic [W-1:0]  busy_r;
  logic [IW:0]   count_r;
  logic          err_r;

  logic [IW-1:0] search_idx_s;
  logic [IW-1:0] grant_idx_s;
  logic          full_s;
  logic          empty_s;
  logic          free_legal_s;
  logic          bypass_s;
  logic          rdy_s;
  logic          accept_s;
  logic          reuse_s;
  logic [W-1:0]  set_s;
  logic [W-1:0]  clr_s;
  logic [W-1:0]  busy_nxt_s;
  logic [IW:0]   count_nxt_s;

  // Priority search: later loop iterations win, so scan order picks lowest or highest free slot.
  always_comb begin
    search_idx_s = IDX_RST;
    for (int i = 0; i < W; i++) begin
      if (LSB != 0) begin
        search_idx_s = busy_r[W-1-i] ? search_idx_s : IW'(W - 1 - i);
      end else begin
        search_idx_s = busy_r[i] ? search_idx_s : IW'(i);
      end
    end
  end

  // Handshake, bypass decision and next-state occupancy/count.
  always_comb begin
    full_s       = (count_r == CNT_FULL);
    empty_s      = (count_r == {(IW + 1){1'b0}});
    free_legal_s = bus.i_free_vld & (|(slot_mask(bus.i_free_idx) & busy_r));
`ifdef U_SLOT_ALLOC_BYPASS_EN
    bypass_s     = full_s & free_legal_s;
`else
    bypass_s     = 1'b0;
`endif
    rdy_s        = ~bus.i_flush & (~full_s | bypass_s);
    grant_idx_s  = bypass_s ? bus.i_free_idx : search_idx_s;
    accept_s     = bus.i_alloc_vld & rdy_s;
    // A bypassed grant hands the freed slot straight back, so occupancy is untouched.
    reuse_s      = accept_s & bypass_s;
    set_s        = (accept_s & ~reuse_s) ? slot_mask(grant_idx_s) : {W{1'b0}};
    clr_s        = (free_legal_s & ~reuse_s) ? slot_mask(bus.i_free_idx) : {W{1'b0}};
    busy_nxt_s   = (busy_r & ~clr_s) | set_s;
    case ({accept_s & ~reuse_s, free_legal_s & ~reuse_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Occupancy, count and sticky error state; flush outranks alloc and free.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      busy_r  <= {W{1'b0}};
      count_r <= {(IW + 1){1'b0}};
      err_r   <= 1'b0;
    end else if (bus.i_flush) begin
      busy_r  <= {W{1'b0}};
      count_r <= {(IW + 1){1'b0}};
      err_r   <= 1'b0;
    end else begin
      busy_r  <= busy_nxt_s;
      count_r <= count_nxt_s;
      err_r   <= err_r | (bus.i_free_vld & ~free_legal_s);
    end
  end

  assign bus.o_busy      = busy_r;
  assign bus.o_count     = count_r;
  assign bus.o_err       = err_r;
  assign bus.o_full      = full_s;
  assign bus.o_empty     = empty_s;
  assign bus.o_alloc_rdy = rdy_s;
  assign bus.o_alloc_idx = grant_idx_s;
endmodule

// File: tb/tb_u_slot_alloc.sv
// tb_u_slot_alloc: scoreboard bench for u_slot_alloc (W=8 LSB=1 modelled, plus W=8 LSB=0 and W=6 directed).
// Expected next-state values are queued when a cycle is driven and compared after the clock edge.
module tb_u_slot_alloc;
  logic clk;
  logic arst_a_n;
  logic arst_n;

  u_slot_alloc_if #(.W(8)) ifa ();
  u_slot_alloc_if #(.W(8)) ifb ();
  u_slot_alloc_if #(.W(6)) ifc ();

  u_slot_alloc #(.W(8), .LSB(1)) dut_a (.clk(clk), .arst_n(arst_a_n), .bus(ifa));
  u_slot_alloc #(.W(8), .LSB(0)) dut_b (.clk(clk), .arst_n(arst_n),   .bus(ifb));
  u_slot_alloc #(.W(6), .LSB(1)) dut_c (.clk(clk), .arst_n(arst_n),   .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] busy;
    logic [3:0] count;
    logic       err;
  } exp_t;

  exp_t       sb_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] m_busy;
  logic [3:0] m_count;
  logic       m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference search for the W=8 lowest-first instance.
  function automatic logic [2:0] m_search(input logic [7:0] b);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!b[i]) begin
        r = 3'(i);
        break;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_busy  = 8'h00;
    m_count = 4'd0;
    m_err   = 1'b0;
  endtask

  // One cycle on dut_a: drive, check handshake, queue next state, then compare after the edge.
  task automatic step_a(input logic av, input logic fv, input logic [2:0] fi, input logic fl);
    exp_t       e;
    exp_t       got;
    logic       full;
    logic       legal;
    logic       byp;
    logic       rdy;
    logic [2:0] idx;
    @(negedge clk);
    ifa.i_alloc_vld = av;
    ifa.i_free_vld  = fv;
    ifa.i_free_idx  = fi;
    ifa.i_flush     = fl;
    #1;
    full  = (m_count == 4'd8);
    legal = fv && m_busy[fi];
    byp   = 1'b0;
`ifdef U_SLOT_ALLOC_BYPASS_EN
    byp   = full && legal;
`endif
    rdy   = !fl && (!full || byp);
    idx   = byp ? fi : m_search(m_busy);
    chk("a_rdy", 64'(ifa.o_alloc_rdy), 64'(rdy));
    if (!full || byp) chk("a_idx", 64'(ifa.o_alloc_idx), 64'(idx));
    if (fl) begin
      model_reset();
    end else begin
      if (!(av && rdy && byp)) begin
        if (av && rdy) begin
          m_busy[idx] = 1'b1;
          m_count     = m_count + 4'd1;
        end
        if (legal) begin
          m_busy[fi] = 1'b0;
          m_count    = m_count - 4'd1;
        end
      end
      if (fv && !legal) m_err = 1'b1;
    end
    e.busy  = m_busy;
    e.count = m_count;
    e.err   = m_err;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("a_sb_empty", 64'(0), 64'(1));
    end else begin
      got = sb_q.pop_front();
      chk("a_busy",  64'(ifa.o_busy),  64'(got.busy));
      chk("a_count", 64'(ifa.o_count), 64'(got.count));
      chk("a_err",   64'(ifa.o_err),   64'(got.err));
      chk("a_full",  64'(ifa.o_full),  64'(got.count == 4'd8));
      chk("a_empty", 64'(ifa.o_empty), 64'(got.count == 4'd0));
    end
  endtask

  initial begin
    arst_a_n = 1'b0;
    arst_n   = 1'b0;
    ifa.i_alloc_vld = 1'b0; ifa.i_free_vld = 1'b0; ifa.i_free_idx = 3'd0; ifa.i_flush = 1'b0;
    ifb.i_alloc_vld = 1'b0; ifb.i_free_vld = 1'b0; ifb.i_free_idx = 3'd0; ifb.i_flush = 1'b0;
    ifc.i_alloc_vld = 1'b0; ifc.i_free_vld = 1'b0; ifc.i_free_idx = 3'd0; ifc.i_flush = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_a_busy",  64'(ifa.o_busy),      64'(8'h00));
    chk("rst_a_count", 64'(ifa.o_count),     64'(4'd0));
    chk("rst_a_empty", 64'(ifa.o_empty),     64'(1'b1));
    chk("rst_a_full",  64'(ifa.o_full),      64'(1'b0));
    chk("rst_a_err",   64'(ifa.o_err),       64'(1'b0));
    chk("rst_a_rdy",   64'(ifa.o_alloc_rdy), 64'(1'b1));
    chk("rst_a_idx",   64'(ifa.o_alloc_idx), 64'(3'd0));
    chk("rst_b_idx",   64'(ifb.o_alloc_idx), 64'(3'd7));
    chk("rst_c_idx",   64'(ifc.o_alloc_idx), 64'(3'd0));
    @(negedge clk);
    arst_a_n = 1'b1;
    arst_n   = 1'b1;

    // Fill: nine requests, eight grants 0..7, the ninth refused.
    for (int i = 0; i < 8; i++) step_a(1'b1, 1'b0, 3'd0, 1'b0);
    chk("fill_full", 64'(ifa.o_full), 64'(1'b1));
    step_a(1'b1, 1'b0, 3'd0, 1'b0);
    chk("fill_busy",  64'(ifa.o_busy),  64'(8'hFF));
    chk("fill_count", 64'(ifa.o_count), 64'(4'd8));

    // Full with alloc + free of slot 4 in the same cycle.
    step_a(1'b1, 1'b1, 3'd4, 1'b0);
`ifdef U_SLOT_ALLOC_BYPASS_EN
    chk("byp_busy", 64'(ifa.o_busy), 64'(8'hFF));
`else
    chk("byp_busy", 64'(ifa.o_busy), 64'(8'hEF));
`endif
    step_a(1'b1, 1'b0, 3'd0, 1'b0);
    chk("byp_after", 64'(ifa.o_busy), 64'(8'hFF));

    // Flush with a concurrent alloc: nothing granted.
    step_a(1'b1, 1'b0, 3'd0, 1'b1);
    chk("flush_busy", 64'(ifa.o_busy), 64'(8'h00));

    // Simultaneous alloc and free at busy = 0x07.
    for (int i = 0; i < 3; i++) step_a(1'b1, 1'b0, 3'd0, 1'b0);
    step_a(1'b1, 1'b1, 3'd1, 1'b0);
    chk("sim_busy",  64'(ifa.o_busy),  64'(8'h0D));
    chk("sim_count", 64'(ifa.o_count), 64'(4'd3));
    step_a(1'b1, 1'b0, 3'd0, 1'b0);
    chk("sim_next", 64'(ifa.o_busy), 64'(8'h0F));

    // Illegal free of an idle slot, sticky error, cleared by flush.
    step_a(1'b0, 1'b0, 3'd0, 1'b1);
    step_a(1'b1, 1'b0, 3'd0, 1'b0);
    step_a(1'b0, 1'b1, 3'd5, 1'b0);
    chk("ill_busy", 64'(ifa.o_busy), 64'(8'h01));
    chk("ill_err",  64'(ifa.o_err),  64'(1'b1));
    step_a(1'b0, 1'b0, 3'd0, 1'b0);
    chk("ill_sticky", 64'(ifa.o_err), 64'(1'b1));
    step_a(1'b1, 1'b1, 3'd0, 1'b1);
    chk("ill_flush_err", 64'(ifa.o_err), 64'(1'b0));

    // Asynchronous reset mid-burst at busy = 0x3F.
    for (int i = 0; i < 6; i++) step_a(1'b1, 1'b0, 3'd0, 1'b0);
    chk("ar_pre", 64'(ifa.o_busy), 64'(8'h3F));
    @(negedge clk);
    ifa.i_alloc_vld = 1'b1;
    #2;
    arst_a_n = 1'b0;
    #1;
    chk("ar_busy",  64'(ifa.o_busy),      64'(8'h00));
    chk("ar_count", 64'(ifa.o_count),     64'(4'd0));
    chk("ar_empty", 64'(ifa.o_empty),     64'(1'b1));
    chk("ar_rdy",   64'(ifa.o_alloc_rdy), 64'(1'b1));
    chk("ar_idx",   64'(ifa.o_alloc_idx), 64'(3'd0));
    @(negedge clk);
    arst_a_n = 1'b1;
    ifa.i_alloc_vld = 1'b0;
    model_reset();
    step_a(1'b1, 1'b0, 3'd0, 1'b0);
    chk("ar_first", 64'(ifa.o_busy), 64'(8'h01));

    // Random traffic against the model.
    for (int i = 0; i < 80; i++) begin
      step_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 15) == 0));
    end
    @(negedge clk);
    ifa.i_alloc_vld = 1'b0; ifa.i_free_vld = 1'b0; ifa.i_flush = 1'b0;

    // LSB=0 instance: fill from the top, free 7..4, then next grant is 7.
    ifb.i_alloc_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("b_fill_idx", 64'(ifb.o_alloc_idx), 64'(7 - i));
      @(negedge clk);
    end
    ifb.i_alloc_vld = 1'b0;
    #1;
    chk("b_full", 64'(ifb.o_full), 64'(1'b1));
    for (int i = 7; i >= 4; i--) begin
      @(negedge clk);
      ifb.i_free_vld = 1'b1;
      ifb.i_free_idx = 3'(i);
    end
    @(negedge clk);
    ifb.i_free_vld = 1'b0;
    #1;
    chk("b_busy_0f", 64'(ifb.o_busy),  64'(8'h0F));
    chk("b_count",   64'(ifb.o_count), 64'(4'd4));
    ifb.i_alloc_vld = 1'b1;
    #1;
    chk("b_idx7", 64'(ifb.o_alloc_idx), 64'(3'd7));
    @(negedge clk);
    ifb.i_alloc_vld = 1'b0;
    #1;
    chk("b_busy_8f", 64'(ifb.o_busy), 64'(8'h8F));

    // W=6 instance: out-of-range frees, flush, and filling to full.
    @(negedge clk);
    ifc.i_alloc_vld = 1'b1;
    @(negedge clk);
    ifc.i_alloc_vld = 1'b0;
    ifc.i_free_vld  = 1'b1;
    ifc.i_free_idx  = 3'd7;
    @(negedge clk);
    ifc.i_free_vld = 1'b0;
    #1;
    chk("c_oor_err",   64'(ifc.o_err),   64'(1'b1));
    chk("c_oor_busy",  64'(ifc.o_busy),  64'(6'h01));
    chk("c_oor_count", 64'(ifc.o_count), 64'(4'd1));
    ifc.i_flush     = 1'b1;
    ifc.i_alloc_vld = 1'b1;
    #1;
    chk("c_flush_rdy", 64'(ifc.o_alloc_rdy), 64'(1'b0));
    @(negedge clk);
    ifc.i_flush     = 1'b0;
    ifc.i_alloc_vld = 1'b0;
    #1;
    chk("c_flush_busy", 64'(ifc.o_busy), 64'(6'h00));
    chk("c_flush_err",  64'(ifc.o_err),  64'(1'b0));
    ifc.i_free_vld = 1'b1;
    ifc.i_free_idx = 3'd6;
    @(negedge clk);
    ifc.i_free_vld = 1'b0;
    #1;
    chk("c_idx6_err", 64'(ifc.o_err), 64'(1'b1));
    ifc.i_alloc_vld = 1'b1;
    repeat (7) @(negedge clk);
    ifc.i_alloc_vld = 1'b0;
    #1;
    chk("c_full_busy",  64'(ifc.o_busy),      64'(6'h3F));
    chk("c_full_count", 64'(ifc.o_count),     64'(4'd6));
    chk("c_full_flag",  64'(ifc.o_full),      64'(1'b1));
    chk("c_full_rdy",   64'(ifc.o_alloc_rdy), 64'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
